// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus master: data/address widths,
// read/write encoding and the access state machine encoding.
package bus_pkg;

    localparam int WORD        = 32;
    localparam int WORD_ADDR_W = 30;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Access sequencing: wait for the CPU, win the arbiter, strobe, wait for the slave
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_e;

    // The master is busy in every state except IDLE
    function automatic logic busy_state(input state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// CPU-to-bus master bridge. Accepts one-cycle CPU access strobes, arbitrates
// for the shared bus, issues a single address-strobe cycle and waits for the
// slave's ready, aborting with an error pulse after TIMEOUT cycles.
// Every output is a flop so no input reaches an output combinationally.
module bus_master_if
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_rw,
    input  logic [WORD_ADDR_W-1:0] cpu_addr,
    input  logic [WORD-1:0]        cpu_wr_data,
    output logic [WORD-1:0]        cpu_rd_data,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic                   cpu_err,
    output logic                   bus_req,
    input  logic                   bus_grnt,
    output logic                   bus_as,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]        bus_wr_data,
    input  logic [WORD-1:0]        bus_rd_data,
    input  logic                   bus_rdy
);

    // Last counter value allowed before the access is abandoned
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD-1:0]        wdata_q, wdata_d;
    logic [WORD-1:0]        rdata_q, rdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   req_q, req_d;
    logic                   as_q, as_d;
    logic                   busy_q, busy_d;

    // Next-state, latch and completion logic for one bus access
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Strobes are only honoured here, so nothing gets queued while busy
                if (cpu_req) begin
                    rw_d    = cpu_rw;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wr_data;
                    state_d = REQ;
                end
            end
            REQ: begin
                // No timeout while waiting for the arbiter
                if (bus_grnt) begin
                    cnt_d   = 8'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS, WAIT: begin
                // Ready wins over the timeout when both land in the same cycle
                if (bus_rdy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (rw_q == RW_READ) begin
                        rdata_d = bus_rd_data;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LIMIT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus-side controls follow the state being entered so they line up with it
        req_d  = (state_d != IDLE);
        as_d   = (state_d == ACCESS);
        busy_d = busy_state(state_d);
    end

    // State, latched access and registered outputs; reset abandons any access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            as_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            as_q    <= as_d;
            busy_q  <= busy_d;
        end
    end

    assign cpu_rd_data = rdata_q;
    assign cpu_busy    = busy_q;
    assign cpu_done    = done_q;
    assign cpu_err     = err_q;
    assign bus_req     = req_q;
    assign bus_as      = as_q;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if with TIMEOUT=8.
module tb_bus_master_if;
    import bus_pkg::*;

    localparam int TO = 8;

    logic                   clk;
    logic                   rst;
    logic                   cpu_req;
    logic                   cpu_rw;
    logic [WORD_ADDR_W-1:0] cpu_addr;
    logic [WORD-1:0]        cpu_wr_data;
    logic [WORD-1:0]        cpu_rd_data;
    logic                   cpu_busy;
    logic                   cpu_done;
    logic                   cpu_err;
    logic                   bus_req;
    logic                   bus_grnt;
    logic                   bus_as;
    logic                   bus_rw;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic [WORD-1:0]        bus_wr_data;
    logic [WORD-1:0]        bus_rd_data;
    logic                   bus_rdy;

    int n_checks = 0;
    int n_errors = 0;

    bus_master_if #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_busy   (cpu_busy),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .bus_req    (bus_req),
        .bus_grnt   (bus_grnt),
        .bus_as     (bus_as),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy    (bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CPU strobe; returns in the cycle after the strobe
    task automatic issue(input logic rw, input logic [29:0] a, input logic [31:0] d);
        cpu_req     = 1'b1;
        cpu_rw      = rw;
        cpu_addr    = a;
        cpu_wr_data = d;
        step();
        cpu_req     = 1'b0;
    endtask

    initial begin
        int as_cnt;
        int done_cnt;

        rst = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        bus_grnt = 1'b0; bus_rd_data = '0; bus_rdy = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        check_val("rst_bus_req",  bus_req, 0);
        check_val("rst_bus_as",   bus_as, 0);
        check_val("rst_busy",     cpu_busy, 0);
        check_val("rst_done",     cpu_done, 0);
        check_val("rst_err",      cpu_err, 0);
        check_val("rst_rd_data",  cpu_rd_data, 0);
        check_val("rst_bus_addr", bus_addr, 0);
        check_val("rst_wr_data",  bus_wr_data, 0);
        check_val("rst_bus_rw",   bus_rw, 0);
        rst = 1'b1;
        step();
        $display("txn reset released");

        // ---------------- immediate read ----------------
        bus_grnt = 1'b1; bus_rdy = 1'b1; bus_rd_data = 32'hDEADBEEF;
        check_val("rd_idle_busy", cpu_busy, 0);
        issue(RW_READ, 30'h10, 32'h0);
        check_val("rd_c1_req",  bus_req, 1);
        check_val("rd_c1_as",   bus_as, 0);
        check_val("rd_c1_busy", cpu_busy, 1);
        check_val("rd_c1_done", cpu_done, 0);
        step();
        check_val("rd_c2_as",   bus_as, 1);
        check_val("rd_c2_req",  bus_req, 1);
        check_val("rd_c2_addr", bus_addr, 32'h10);
        check_val("rd_c2_rw",   bus_rw, 1);
        check_val("rd_c2_done", cpu_done, 0);
        step();
        check_val("rd_c3_done", cpu_done, 1);
        check_val("rd_c3_err",  cpu_err, 0);
        check_val("rd_c3_data", cpu_rd_data, 32'hDEADBEEF);
        check_val("rd_c3_as",   bus_as, 0);
        check_val("rd_c3_req",  bus_req, 0);
        check_val("rd_c3_busy", cpu_busy, 0);
        step();
        check_val("rd_c4_done", cpu_done, 0);
        $display("txn immediate read addr=0x%08h data=0x%08h", 32'h10, cpu_rd_data);

        // ---------------- delayed write ----------------
        bus_grnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = 32'hBAD0BAD0;
        issue(RW_WRITE, 30'h2000_0000, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            check_val("wr_req_phase_req",  bus_req, 1);
            check_val("wr_req_phase_as",   bus_as, 0);
            check_val("wr_req_phase_addr", bus_addr, 32'h2000_0000);
            check_val("wr_req_phase_data", bus_wr_data, 32'h12345678);
            step();
        end
        check_val("wr_req5_as", bus_as, 0);
        bus_grnt = 1'b1;
        step();
        check_val("wr_acc_as", bus_as, 1);
        check_val("wr_acc_rw", bus_rw, 0);
        bus_grnt = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin
            check_val("wr_wait_req",  bus_req, 1);
            check_val("wr_wait_as",   bus_as, 0);
            check_val("wr_wait_done", cpu_done, 0);
            check_val("wr_wait_addr", bus_addr, 32'h2000_0000);
            check_val("wr_wait_data", bus_wr_data, 32'h12345678);
            step();
        end
        check_val("wr_wait4_req", bus_req, 1);
        bus_rdy = 1'b1;
        step();
        check_val("wr_done",      cpu_done, 1);
        check_val("wr_err",       cpu_err, 0);
        check_val("wr_rd_data",   cpu_rd_data, 32'hDEADBEEF);
        check_val("wr_done_req",  bus_req, 0);
        bus_rdy = 1'b0;
        step();
        check_val("wr_after_done", cpu_done, 0);
        $display("txn delayed write addr=0x%08h data=0x%08h", 32'h2000_0000, 32'h12345678);

        // ---------------- timeout ----------------
        bus_grnt = 1'b1; bus_rdy = 1'b0; bus_rd_data = 32'h55555555;
        issue(RW_READ, 30'h5, 32'h0);
        step();
        check_val("to_acc_as", bus_as, 1);
        for (int k = 1; k < TO; k++) begin
            step();
            check_val("to_wait_done", cpu_done, 0);
            check_val("to_wait_req",  bus_req, 1);
            check_val("to_wait_as",   bus_as, 0);
        end
        step();
        check_val("to_done",      cpu_done, 1);
        check_val("to_err",       cpu_err, 1);
        check_val("to_rd_data",   cpu_rd_data, 32'hDEADBEEF);
        check_val("to_done_req",  bus_req, 0);
        check_val("to_done_busy", cpu_busy, 0);
        step();
        check_val("to_after_done", cpu_done, 0);
        check_val("to_after_err",  cpu_err, 0);
        check_val("to_after_req",  bus_req, 0);
        $display("txn timeout read addr=0x%08h err after %0d cycles", 32'h5, TO);

        // ---------------- ready at the timeout limit ----------------
        bus_rd_data = 32'hCAFEF00D;
        issue(RW_READ, 30'h6, 32'h0);
        step();
        for (int k = 1; k < TO; k++) begin
            step();
            check_val("bd_wait_done", cpu_done, 0);
        end
        bus_rdy = 1'b1;
        step();
        check_val("bd_done",    cpu_done, 1);
        check_val("bd_err",     cpu_err, 0);
        check_val("bd_rd_data", cpu_rd_data, 32'hCAFEF00D);
        bus_rdy = 1'b0;
        step();
        $display("txn boundary read addr=0x%08h data=0x%08h", 32'h6, cpu_rd_data);

        // ---------------- strobe while busy ----------------
        bus_rd_data = 32'h11112222;
        as_cnt = 0;
        done_cnt = 0;
        issue(RW_READ, 30'h7, 32'h0);
        for (int c = 1; c <= 14; c++) begin
            if (bus_as)   as_cnt++;
            if (cpu_done) done_cnt++;
            if (c == 3) begin
                cpu_req  = 1'b1;
                cpu_rw   = RW_WRITE;
                cpu_addr = 30'h3FF;
            end
            if (c == 4) begin
                cpu_req = 1'b0;
                bus_rdy = 1'b1;
                check_val("sb_addr_held", bus_addr, 32'h7);
                check_val("sb_rw_held",   bus_rw, 1);
            end
            if (c == 5) bus_rdy = 1'b0;
            step();
        end
        check_val("sb_as_pulses",   as_cnt, 1);
        check_val("sb_done_pulses", done_cnt, 1);
        check_val("sb_rd_data",     cpu_rd_data, 32'h11112222);
        check_val("sb_idle_busy",   cpu_busy, 0);
        $display("txn strobe-while-busy as=%0d done=%0d", as_cnt, done_cnt);

        // ---------------- reset during WAIT ----------------
        bus_grnt = 1'b1; bus_rdy = 1'b0;
        issue(RW_READ, 30'h9, 32'h0);
        step();
        step();
        check_val("rw_pre_req", bus_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("rw_req_fell",  bus_req, 0);
        check_val("rw_as_low",    bus_as, 0);
        check_val("rw_busy_low",  cpu_busy, 0);
        check_val("rw_done_low",  cpu_done, 0);
        check_val("rw_rd_data",   cpu_rd_data, 0);
        check_val("rw_bus_addr",  bus_addr, 0);
        step();
        check_val("rw_hold_done", cpu_done, 0);
        step();
        check_val("rw_hold2_done", cpu_done, 0);
        rst = 1'b1;
        step();
        check_val("rw_post_done", cpu_done, 0);
        bus_rdy = 1'b1; bus_rd_data = 32'h0BADCAFE;
        issue(RW_READ, 30'h20, 32'h0);
        check_val("rw_next_req", bus_req, 1);
        step();
        check_val("rw_next_as", bus_as, 1);
        step();
        check_val("rw_next_done", cpu_done, 1);
        check_val("rw_next_err",  cpu_err, 0);
        check_val("rw_next_data", cpu_rd_data, 32'h0BADCAFE);
        bus_rdy = 1'b0;
        step();
        $display("txn reset-in-wait then read addr=0x%08h data=0x%08h", 32'h20, cpu_rd_data);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles a bus access waits for slave ready; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted when rst=0.
REQ-004 cpu_req  input  1  access strobe, one cycle; SHALL be accepted only in IDLE.
REQ-005 cpu_rw  input  1  1=read, 0=write; sampled with cpu_req.
REQ-006 cpu_addr  input  30  word address; sampled with cpu_req.
REQ-007 cpu_wr_data  input  32  write data; sampled with cpu_req.
REQ-008 cpu_rd_data  output  32  last read data; valid from cpu_done until the next read completes.
REQ-009 cpu_busy  output  1  1 whenever state is not IDLE.
REQ-010 cpu_done  output  1  one-cycle completion pulse.
REQ-011 cpu_err  output  1  one-cycle timeout pulse, coincident with cpu_done.
REQ-012 bus_req  output  1  bus request to the arbiter, active-high.
REQ-013 bus_grnt  input  1  grant from the arbiter, active-high.
REQ-014 bus_as  output  1  address strobe, active-high.
REQ-015 bus_rw  output  1  1=read, 0=write.
REQ-016 bus_addr  output  30  latched access address.
REQ-017 bus_wr_data  output  32  latched write data.
REQ-018 bus_rd_data  input  32  slave read data from the bus.
REQ-019 bus_rdy  input  1  slave ready, active-high.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, REQ, ACCESS and WAIT.
- IDLE: on cpu_req=1, latch rw, addr and wr_data into registers, then go to REQ; otherwise stay in IDLE.
- REQ: bus_req=1; on bus_grnt=1, go to ACCESS; otherwise stay in REQ indefinitely, with no timeout.
- ACCESS: bus_req=1 and bus_as=1, for exactly one cycle.
- ACCESS/WAIT on bus_rdy=1: go to IDLE.
- ACCESS with bus_rdy=0: go to WAIT.
- WAIT: bus_req=1, bus_as=0; on bus_rdy=1 or timeout, go to IDLE.
REQ-021 bus_addr, bus_rw and bus_wr_data SHALL hold the latched values from REQ through WAIT, unchanged.
REQ-022 On a read, the cycle that samples bus_rdy=1 SHALL load bus_rd_data into cpu_rd_data; a write SHALL leave cpu_rd_data unchanged.
REQ-023 cpu_done SHALL be 1 in the first IDLE cycle after ACCESS or WAIT, and only then.
REQ-024 Minimum latency SHALL be 3 cycles, measured from the cpu_req cycle to the cpu_done cycle (grant and ready both immediate).
REQ-025 Timeout counter behaviour:
- The counter SHALL clear on entry to ACCESS.
- It SHALL increment each ACCESS/WAIT cycle with bus_rdy=0.
- When it reaches TIMEOUT-1 with bus_rdy=0, the FSM SHALL go to IDLE with cpu_done=1 and cpu_err=1, and cpu_rd_data unchanged.
REQ-026 bus_rdy=1 in the same cycle as the timeout limit SHALL complete normally, with no error.
REQ-027 cpu_req while cpu_busy=1 SHALL be ignored, and no request SHALL be queued.
REQ-028 bus_grnt SHALL be sampled only in REQ; its value in ACCESS/WAIT SHALL be ignored.
REQ-029 bus_req SHALL drop to 0 in the cpu_done cycle, releasing the arbiter.
REQ-030 cpu_busy SHALL be registered and derived from state only, with no combinational path from any input.

Reset
REQ-031 On rst=0, all of the following SHALL be set asynchronously:
- state=IDLE and counter=0;
- all outputs 0, including cpu_rd_data=0 and bus_addr=0.
REQ-032 Reset mid-access SHALL abandon the access without cpu_done, and bus_req/bus_as SHALL fall immediately.
REQ-033 The first cpu_req after reset release SHALL be accepted normally.

Structure
REQ-034 The shared package bus_pkg SHALL hold:
- WORD=32 and WORD_ADDR_W=30;
- the RW_READ=1 and RW_WRITE=0 constants;
- the 2-bit state encoding type.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Immediate read: read of addr 0x0000_0010, grnt=1, rdy=1 in ACCESS -> bus_as high for 1 cycle; cpu_done 3 cycles after cpu_req; cpu_rd_data equals driven 0xDEADBEEF.
- Delayed write: write of 0x12345678 to addr 0x2000_0000, grnt held 0 for 4 cycles, rdy after 3 WAIT cycles -> bus_req high throughout; address and data stable; cpu_rd_data unchanged; cpu_err=0.
- Timeout: TIMEOUT=8, rdy never asserted -> cpu_done=cpu_err=1 exactly 8 cycles after ACCESS; bus_req=0 after that.
- Boundary: rdy=1 exactly at the timeout-limit cycle -> normal completion; cpu_err=0.
- Strobe while busy: second cpu_req during WAIT -> ignored; exactly one bus_as pulse and one cpu_done.
- Reset in WAIT: rst=0 in WAIT -> bus_req and bus_as fall without a clock edge; no cpu_done; next access completes normally.
